// File: rtl/i2c_seq_pkg.sv
// Shared constants and state encoding for the I2C register-bus sequencer.
package i2c_seq_pkg;

  // Core register map
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;

  // CR command bits
  localparam int CR_STA = 7;
  localparam int CR_STO = 6;
  localparam int CR_RD  = 5;
  localparam int CR_WR  = 4;
  localparam int CR_ACK = 3;

  // SR status bits
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  // CR command bytes and CTR values
  localparam logic [7:0] CR_START_WR    = 8'h90;
  localparam logic [7:0] CR_WR_BYTE     = 8'h10;
  localparam logic [7:0] CR_WR_STOP     = 8'h50;
  localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CR_STOP        = 8'h40;
  localparam logic [7:0] CTR_ENABLE     = 8'h80;
  localparam logic [7:0] CTR_DISABLE    = 8'h00;

  // Response codes
  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_ARB  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [3:0] {
    S_INIT_PLO, S_INIT_PHI, S_INIT_CTR, S_IDLE, S_LOAD_TXR, S_WRITE_CR,
    S_POLL_SR, S_EVAL, S_READ_RXR, S_SEND_STOP, S_WAIT_IDLE, S_RESPOND,
    S_ABORT_CTR
  } seq_state_t;

  // CR byte issued for a given byte step of a write or read transaction
  function automatic logic [7:0] cr_for_step(input logic rnw, input logic [1:0] step);
    case (step)
      2'd0:    return CR_START_WR;
      2'd1:    return CR_WR_BYTE;
      2'd2:    return rnw ? CR_START_WR : CR_WR_STOP;
      default: return CR_RD_NACK_STO;
    endcase
  endfunction

endpackage

// File: rtl/i2c_seq_wb_access.sv
// Single-access bus engine: launches one strobe per request, holds the
// address/data stable until acknowledged, returns a one-cycle done pulse.
module i2c_seq_wb_access (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic [2:0] adr_i,
  input  logic       we_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic [7:0] m_dat_i,
  input  logic       m_ack_i
);

  logic       stb_q, we_q, done_q;
  logic [2:0] adr_q;
  logic [7:0] dat_q, rdata_q;

  // Strobe/ack handshake; read data is captured on the ack cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 3'd0;
      dat_q   <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stb_q) begin
        if (m_ack_i) begin
          stb_q   <= 1'b0;
          done_q  <= 1'b1;
          rdata_q <= m_dat_i;
        end
      end else if (req_i) begin
        stb_q <= 1'b1;
        adr_q <= adr_i;
        we_q  <= we_i;
        dat_q <= wdata_i;
      end
    end
  end

  assign m_stb_o = stb_q;
  assign m_we_o  = we_q;
  assign m_adr_o = adr_q;
  assign m_dat_o = dat_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Autonomous sequencer for the I2C master core: programs the prescaler after
// reset, then runs single-register writes/reads from a valid/ready command port.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE   = 16'd53,
  parameter logic [15:0] POLL_LIMIT = 16'd65535
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rnw_i,
  input  logic [6:0] cmd_dev_i,
  input  logic [7:0] cmd_reg_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic [1:0] rsp_err_o,
  output logic [2:0] m_adr_o,
  output logic [7:0] m_dat_o,
  input  logic [7:0] m_dat_i,
  output logic       m_we_o,
  output logic       m_stb_o,
  input  logic       m_ack_i
);

  seq_state_t  state_q, state_d;
  logic [1:0]  step_q, step_d, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        issued_q, issued_d, rnw_q, rnw_d, rsp_valid_q, rsp_valid_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d, wdat_q, wdat_d, rx_q, rx_d, rdata_q, rdata_d;

  logic        need_acc, acc_req, acc_we, acc_done, poll_last, last_step;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_wdat, acc_rdata, txr_byte;

  i2c_seq_wb_access u_acc (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .req_i   (acc_req),
    .adr_i   (acc_adr),
    .we_i    (acc_we),
    .wdata_i (acc_wdat),
    .done_o  (acc_done),
    .rdata_o (acc_rdata),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_we_o  (m_we_o),
    .m_stb_o (m_stb_o),
    .m_dat_i (m_dat_i),
    .m_ack_i (m_ack_i)
  );

  // Timeout fires on the POLL_LIMIT-th unsatisfied SR read
  assign poll_last = (cnt_q + 16'd1) == POLL_LIMIT;
  assign last_step = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);

  // TXR content for the current byte step
  always_comb begin
    txr_byte = 8'h00;
    case (step_q)
      2'd0:    txr_byte = {dev_q, 1'b0};
      2'd1:    txr_byte = reg_q;
      2'd2:    txr_byte = rnw_q ? {dev_q, 1'b1} : wdat_q;
      default: txr_byte = 8'h00;
    endcase
  end

  // Next-state, bus-access selection and response bookkeeping
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    issued_d    = issued_q;
    rnw_d       = rnw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdat_d      = wdat_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    need_acc    = 1'b0;
    acc_req     = 1'b0;
    acc_adr     = ADR_PRERLO;
    acc_we      = 1'b0;
    acc_wdat    = 8'h00;
    case (state_q)
      S_INIT_PLO: begin
        need_acc = 1'b1; acc_adr = ADR_PRERLO; acc_we = 1'b1; acc_wdat = PRESCALE[7:0];
        if (acc_done) state_d = S_INIT_PHI;
      end
      S_INIT_PHI: begin
        need_acc = 1'b1; acc_adr = ADR_PRERHI; acc_we = 1'b1; acc_wdat = PRESCALE[15:8];
        if (acc_done) state_d = S_INIT_CTR;
      end
      S_INIT_CTR: begin
        need_acc = 1'b1; acc_adr = ADR_CTR; acc_we = 1'b1; acc_wdat = CTR_ENABLE;
        if (acc_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (cmd_valid_i) begin
          rnw_d   = cmd_rnw_i;
          dev_d   = cmd_dev_i;
          reg_d   = cmd_reg_i;
          wdat_d  = cmd_wdata_i;
          step_d  = 2'd0;
          err_d   = ERR_OK;
          state_d = S_LOAD_TXR;
        end
      end
      S_LOAD_TXR: begin
        need_acc = 1'b1; acc_adr = ADR_TXR; acc_we = 1'b1; acc_wdat = txr_byte;
        if (acc_done) state_d = S_WRITE_CR;
      end
      S_WRITE_CR: begin
        need_acc = 1'b1; acc_adr = ADR_CR; acc_we = 1'b1; acc_wdat = cr_for_step(rnw_q, step_q);
        if (acc_done) begin
          cnt_d   = 16'd0;
          state_d = S_POLL_SR;
        end
      end
      S_POLL_SR: begin
        need_acc = 1'b1; acc_adr = ADR_CR;
        if (acc_done) begin
          if (!acc_rdata[SR_TIP]) state_d = S_EVAL;
          else if (poll_last) begin
            err_d   = ERR_TMO;
            state_d = S_ABORT_CTR;
          end else cnt_d = cnt_q + 16'd1;
        end
      end
      S_EVAL: begin
        // acc_rdata still holds the final SR read of this step
        if (acc_rdata[SR_AL]) begin
          err_d   = ERR_ARB;
          cnt_d   = 16'd0;
          state_d = S_WAIT_IDLE;
        end else if (!(rnw_q && step_q == 2'd3) && acc_rdata[SR_RXACK]) begin
          err_d   = ERR_NACK;
          state_d = S_SEND_STOP;
        end else if (last_step) begin
          cnt_d   = 16'd0;
          state_d = rnw_q ? S_READ_RXR : S_WAIT_IDLE;
        end else begin
          step_d  = step_q + 2'd1;
          // the final read step only issues CR, TXR is not reloaded
          state_d = (rnw_q && step_q == 2'd2) ? S_WRITE_CR : S_LOAD_TXR;
        end
      end
      S_READ_RXR: begin
        need_acc = 1'b1; acc_adr = ADR_TXR;
        if (acc_done) begin
          rx_d    = acc_rdata;
          cnt_d   = 16'd0;
          state_d = S_WAIT_IDLE;
        end
      end
      S_SEND_STOP: begin
        need_acc = 1'b1; acc_adr = ADR_CR; acc_we = 1'b1; acc_wdat = CR_STOP;
        if (acc_done) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        need_acc = 1'b1; acc_adr = ADR_CR;
        if (acc_done) begin
          if (!acc_rdata[SR_BUSY]) begin
            rsp_valid_d = 1'b1;
            if (err_q == ERR_OK && rnw_q) rdata_d = rx_q;
            state_d = S_RESPOND;
          end else if (poll_last) begin
            err_d   = ERR_TMO;
            state_d = S_ABORT_CTR;
          end else cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      S_ABORT_CTR: begin
        // disable the core, then re-run INIT and report the timeout on entry
        need_acc = 1'b1; acc_adr = ADR_CTR; acc_we = 1'b1; acc_wdat = CTR_DISABLE;
        if (acc_done) begin
          rsp_valid_d = 1'b1;
          state_d     = S_INIT_PLO;
        end
      end
      default: state_d = S_INIT_PLO;
    endcase
    if (acc_done) issued_d = 1'b0;
    else if (need_acc && !issued_q) begin
      acc_req  = 1'b1;
      issued_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_INIT_PLO;
      step_q      <= 2'd0;
      cnt_q       <= 16'd0;
      err_q       <= ERR_OK;
      issued_q    <= 1'b0;
      rnw_q       <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'h00;
      wdat_q      <= 8'h00;
      rx_q        <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      issued_q    <= issued_d;
      rnw_q       <= rnw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdat_q      <= wdat_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench: a slave/core model answers the bus, a reference model
// predicts the register-write trace and response of each command.
module tb_i2c_reg_sequencer;

  localparam logic [6:0] SLV_DEV = 7'h4C;

  logic       clk = 1'b0, rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [6:0] cmd_dev = 7'd0;
  logic [7:0] cmd_reg = 8'h00, cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] m_adr;
  logic [7:0] m_dat_o, m_dat_i;
  logic       m_we, m_stb, ack;

  i2c_reg_sequencer #(.PRESCALE(16'd53), .POLL_LIMIT(16'd8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rnw_i(cmd_rnw),
    .cmd_dev_i(cmd_dev), .cmd_reg_i(cmd_reg), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .m_adr_o(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_we_o(m_we),
    .m_stb_o(m_stb), .m_ack_i(ack)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [2:0] adr; logic [7:0] dat; int polls; } wr_t;
  typedef struct { logic [1:0] err; logic [7:0] rdata; } rsp_t;
  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];

  int   vectors = 0, miscompares = 0, wr_cnt = 0, polls = 0;
  bit   hang = 0, fin = 0;
  logic al_inject = 1'b0, tip_stuck = 1'b0;
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd;

  function automatic logic [7:0] mem_init(input logic [7:0] a);
    return (a * 8'h1D) ^ 8'h0D;
  endfunction

  // ---------------- I2C core + slave device model ----------------
  logic [7:0] slv_mem [256];
  logic [7:0] c_txr, c_rxr, c_ptr;
  logic       c_tip, c_busy, c_al, c_rxack, c_sto_pend, c_addr;
  int         c_left, c_idx;

  assign m_dat_i = (m_adr == 3'd4) ? {c_rxack, c_busy, c_al, 3'b000, c_tip, 1'b0} :
                   (m_adr == 3'd3) ? c_rxr : 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0; c_tip <= 1'b0; c_busy <= 1'b0; c_al <= 1'b0; c_rxack <= 1'b0;
      c_sto_pend <= 1'b0; c_addr <= 1'b0; c_idx <= 0; c_left <= 0;
      c_txr <= 8'h00; c_rxr <= 8'h00; c_ptr <= 8'h00;
      for (int i = 0; i < 256; i++) slv_mem[i] <= mem_init(8'(i));
    end else begin
      ack <= m_stb && !ack && ($urandom_range(0, 2) != 0);
      if (m_stb && ack) begin
        if (m_we) begin
          if (m_adr == 3'd2 && m_dat_o == 8'h00) begin
            c_tip <= 1'b0; c_busy <= 1'b0; c_al <= 1'b0; c_sto_pend <= 1'b0;
          end else if (m_adr == 3'd3) c_txr <= m_dat_o;
          else if (m_adr == 3'd4) begin
            if (m_dat_o[7] && al_inject) begin
              c_al <= 1'b1; c_tip <= 1'b0; c_busy <= 1'b0;
            end else begin
              c_al   <= 1'b0;
              c_tip  <= 1'b1;
              c_left <= $urandom_range(0, 3);
              if (m_dat_o[7]) c_busy <= 1'b1;
              if (m_dat_o[6]) c_sto_pend <= 1'b1;
              if (m_dat_o[4]) begin
                if (m_dat_o[7]) begin
                  c_addr  <= (c_txr[7:1] == SLV_DEV);
                  c_rxack <= (c_txr[7:1] != SLV_DEV);
                  c_idx   <= 0;
                end else if (c_addr) begin
                  c_rxack <= 1'b0;
                  if (c_idx == 0) c_ptr <= c_txr;
                  else begin slv_mem[c_ptr] <= c_txr; c_ptr <= c_ptr + 8'd1; end
                  c_idx <= c_idx + 1;
                end else c_rxack <= 1'b1;
              end
              if (m_dat_o[5]) c_rxr <= slv_mem[c_ptr];
            end
          end
        end else if (m_adr == 3'd4 && c_tip) begin
          if (c_left == 0 && !tip_stuck) begin
            c_tip <= 1'b0;
            if (c_sto_pend) begin c_busy <= 1'b0; c_sto_pend <= 1'b0; end
          end else if (c_left > 0) c_left <= c_left - 1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    wr_t  e;
    rsp_t r;
    int   cyc;
    bit   hang_seen, fin_seen;
    cyc = 0; hang_seen = 0; fin_seen = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        vectors++;
        polls = 0;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 2'd0 ||
            m_stb !== 1'b0 || m_we !== 1'b0 || m_adr !== 3'd0 || m_dat_o !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_state got rdy=%b vld=%b rd=%02h err=%0d stb=%b we=%b adr=%0d dat=%02h need all zero",
                   cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_stb, m_we, m_adr, m_dat_o);
        end
      end else begin
        if (m_stb && ack) begin
          if (m_we) begin
            vectors++;
            if (exp_wr.size() == 0) begin
              miscompares++;
              $display("FAIL bus_write unexpected adr=%0d dat=%02h", m_adr, m_dat_o);
            end else begin
              e = exp_wr.pop_front();
              if (m_adr !== e.adr || m_dat_o !== e.dat || (e.polls >= 0 && polls != e.polls)) begin
                miscompares++;
                $display("FAIL bus_write got adr=%0d dat=%02h polls=%0d expected adr=%0d dat=%02h polls=%0d",
                         m_adr, m_dat_o, polls, e.adr, e.dat, e.polls);
              end
            end
            polls = 0;
            wr_cnt++;
          end else if (m_adr == 3'd4) polls++;
        end
        if (rsp_valid) begin
          vectors++;
          if (exp_rsp.size() == 0) begin
            miscompares++;
            $display("FAIL response unexpected err=%0d rdata=%02h", rsp_err, rsp_rdata);
          end else begin
            r = exp_rsp.pop_front();
            if (rsp_err !== r.err || rsp_rdata !== r.rdata) begin
              miscompares++;
              $display("FAIL response got err=%0d rdata=%02h expected err=%0d rdata=%02h",
                       rsp_err, rsp_rdata, r.err, r.rdata);
            end
          end
        end
      end
      if (hang && !hang_seen) begin
        hang_seen = 1; vectors++; miscompares++;
        $display("FAIL wait_bound expired wr_left=%0d rsp_left=%0d ready=%b", exp_wr.size(), exp_rsp.size(), cmd_ready);
      end
      if (fin && !fin_seen) begin
        fin_seen = 1; vectors++;
        if (exp_wr.size() != 0 || exp_rsp.size() != 0) begin
          miscompares++;
          $display("FAIL drain got wr_left=%0d rsp_left=%0d expected 0/0", exp_wr.size(), exp_rsp.size());
        end
      end
      if (cyc > 80000) begin
        vectors++; miscompares++;
        $display("FAIL global_timeout cycles=%0d limit=80000", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  // ---------------- reference model + stimulus ----------------
  task automatic pushw(input logic [2:0] a, input logic [7:0] d, input int p);
    wr_t e;
    e.adr = a; e.dat = d; e.polls = p;
    exp_wr.push_back(e);
  endtask

  task automatic pushr(input logic [1:0] err);
    rsp_t r;
    r.err = err; r.rdata = last_rd;
    exp_rsp.push_back(r);
  endtask

  task automatic push_init();
    pushw(3'd0, 8'h35, -1); pushw(3'd1, 8'h00, -1); pushw(3'd2, 8'h80, -1);
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
    last_rd = 8'h00;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (n < 5000 && !(exp_wr.size() == 0 && exp_rsp.size() == 0 && cmd_ready)) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) hang = 1;
  endtask

  // mode: 0 normal, 1 arbitration lost on first START, 2 TIP stuck
  task automatic issue(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input int mode, input bit wait_done);
    int n;
    pushw(3'd3, {dev, 1'b0}, -1); pushw(3'd4, 8'h90, -1);
    if (mode == 2) begin
      pushw(3'd2, 8'h00, 8); push_init(); pushr(2'd3);
    end else if (mode == 1) pushr(2'd2);
    else if (dev != SLV_DEV) begin
      pushw(3'd4, 8'h40, -1); pushr(2'd1);
    end else if (!rnw) begin
      pushw(3'd3, rg, -1); pushw(3'd4, 8'h10, -1); pushw(3'd3, wd, -1); pushw(3'd4, 8'h50, -1);
      ref_mem[rg] = wd; pushr(2'd0);
    end else begin
      pushw(3'd3, rg, -1); pushw(3'd4, 8'h10, -1); pushw(3'd3, {dev, 1'b1}, -1);
      pushw(3'd4, 8'h90, -1); pushw(3'd4, 8'h68, -1);
      last_rd = ref_mem[rg]; pushr(2'd0);
    end
    n = 0;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) hang = 1;
    cmd_rnw = rnw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = ~wd;  // later changes must not leak into the latched command
    if (wait_done) wait_quiet();
  endtask

  initial begin : stimulus
    int base, n, mode;
    logic [6:0] dev;
    ref_reset();
    #1 rst = 1'b1;
    push_init();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_quiet();

    issue(1'b0, SLV_DEV, 8'h12, 8'hA5, 0, 1);   // write
    issue(1'b1, SLV_DEV, 8'h03, 8'h00, 0, 1);   // read -> 0x5A
    issue(1'b0, 7'h21,   8'h10, 8'h33, 0, 1);   // absent device
    tip_stuck = 1'b1;
    issue(1'b1, SLV_DEV, 8'h04, 8'h00, 2, 1);   // timeout + re-init
    tip_stuck = 1'b0;
    al_inject = 1'b1;
    issue(1'b0, SLV_DEV, 8'h05, 8'h77, 1, 1);   // arbitration lost
    al_inject = 1'b0;
    issue(1'b1, SLV_DEV, 8'h12, 8'h00, 0, 1);   // reads back 0xA5, rdata after AL

    // reset during step1 of a read
    base = wr_cnt;
    issue(1'b1, SLV_DEV, 8'h07, 8'h00, 0, 0);
    n = 0;
    while (wr_cnt < base + 3 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) hang = 1;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_wr.delete(); exp_rsp.delete();
    ref_reset();
    push_init();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_quiet();
    issue(1'b1, SLV_DEV, 8'h07, 8'h00, 0, 1);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      dev = SLV_DEV;
      if ($urandom_range(0, 3) == 0) begin
        dev = 7'($urandom_range(0, 127));
        if (dev == SLV_DEV) dev = 7'h21;
      end
      n = $urandom_range(0, 19);
      mode = (n == 0) ? 1 : (n == 1) ? 2 : 0;
      al_inject = (mode == 1);
      tip_stuck = (mode == 2);
      issue(1'($urandom_range(0, 1)), dev, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), mode, 1);
      al_inject = 1'b0;
      tip_stuck = 1'b0;
    end

    repeat (5) @(negedge clk);
    fin = 1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
